// File: rtl/fifo_rd_packer_if.sv
// Packed-word output stream of fifo_rd_packer.
// Master drives data/keep/valid, slave returns ready.
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4
);
    logic [DATA_WIDTH*PACK_NUM-1:0] out_data;
    logic [PACK_NUM-1:0]            out_keep;
    logic                           out_valid;
    logic                           out_ready;

    modport master (
        output out_data,
        output out_keep,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_keep,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs PACK_NUM elements per output word,
// with partial words emitted on flush or idle timeout.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4,
    parameter int CNT_WIDTH  = 3,
    parameter int TIMEOUT    = 16,
    parameter int TO_WIDTH   = 5
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    input  logic                  flush,
    fifo_rd_packer_if.master      out
);
    localparam int WW = DATA_WIDTH * PACK_NUM;
    localparam logic [CNT_WIDTH:0] FULL_CNT = (CNT_WIDTH+1)'(PACK_NUM);
    localparam logic [TO_WIDTH-1:0] TO_MAX = TO_WIDTH'(TIMEOUT);

    logic [CNT_WIDTH-1:0] fill;
    logic                 pend;
    logic                 flush_pend;
    logic [TO_WIDTH-1:0]  to_cnt;
    logic [WW-1:0]        pack;

    logic [CNT_WIDTH:0]   occ;
    logic                 full;
    logic                 out_free;
    logic                 to_hit;
    logic                 xfer;
    logic [PACK_NUM-1:0]  keep_n;

    // occupancy counts the in-flight element so a pop never overfills
    assign occ = {1'b0, fill} + {{CNT_WIDTH{1'b0}}, pend};
    assign full = ({1'b0, fill} == FULL_CNT);
    assign rd_en = !fifo_empty && !flush_pend && (occ < FULL_CNT);
    assign out_free = !out.out_valid || out.out_ready;
    assign to_hit = (TIMEOUT != 0) && (to_cnt == TO_MAX);
    assign xfer = out_free &&
                  (full || (fill != '0 && !pend && (flush_pend || to_hit)));

    always_comb begin
        keep_n = '0;
        for (int i = 0; i < PACK_NUM; i++) begin
            keep_n[i] = ({1'b0, fill} > (CNT_WIDTH+1)'(i));
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            fill <= '0;
            pend <= 1'b0;
            pack <= '0;
        end else begin
            pend <= rd_en;
            if (xfer) begin
                fill <= '0;
                pack <= '0;
            end else if (pend) begin
                fill <= fill + 1'b1;
                for (int i = 0; i < PACK_NUM; i++) begin
                    if (fill == CNT_WIDTH'(i)) begin
                        pack[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
                    end
                end
            end
        end
    end

    // a flush seen during a full-word transfer lands on the empty fill
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end else if (xfer || (fill == '0 && !pend)) begin
            flush_pend <= 1'b0;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            to_cnt <= '0;
        end else if (rd_en || xfer || fill == '0) begin
            to_cnt <= '0;
        end else if (!full && to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            out.out_data  <= '0;
            out.out_keep  <= '0;
            out.out_valid <= 1'b0;
        end else if (xfer) begin
            out.out_data  <= pack;
            out.out_keep  <= keep_n;
            out.out_valid <= 1'b1;
        end else if (out.out_ready) begin
            out.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: FIFO models feed two DUTs,
// a monitor checks every accepted word against the pushed element stream.
module tb_fifo_rd_packer;
    localparam int DW = 8;
    localparam int PN = 4;
    localparam int WW = DW * PN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic          empty_a = 1'b1;
    logic          rd_en_a;
    logic          flush_a = 1'b0;
    logic [DW-1:0] rd_data_a = '0;
    fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_NUM(PN)) oa ();

    fifo_rd_packer #(
        .DATA_WIDTH(DW), .PACK_NUM(PN), .CNT_WIDTH(3),
        .TIMEOUT(16), .TO_WIDTH(5)
    ) dut (
        .rd_clk(clk), .rd_rst_n(rst_n), .fifo_empty(empty_a),
        .rd_data(rd_data_a), .rd_en(rd_en_a), .flush(flush_a),
        .out(oa)
    );

    logic          empty_b = 1'b1;
    logic          rd_en_b;
    logic          flush_b = 1'b0;
    logic [DW-1:0] rd_data_b = '0;
    fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_NUM(PN)) ob ();

    fifo_rd_packer #(
        .DATA_WIDTH(DW), .PACK_NUM(PN), .CNT_WIDTH(3),
        .TIMEOUT(0), .TO_WIDTH(5)
    ) dut0 (
        .rd_clk(clk), .rd_rst_n(rst_n), .fifo_empty(empty_b),
        .rd_data(rd_data_b), .rd_en(rd_en_b), .flush(flush_b),
        .out(ob)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO models: pop decided mid-cycle, data returned after the edge
    logic [DW-1:0] fa[$];
    logic [DW-1:0] fb[$];
    logic pop_a = 1'b0;
    logic pop_b = 1'b0;
    int   pops_a = 0;
    int   last_pop_a = 0;

    always @(negedge clk) begin
        pop_a = rst_n && rd_en_a;
        pop_b = rst_n && rd_en_b;
        if (pop_a) begin
            pops_a++;
            last_pop_a = cyc;
        end
    end

    always @(posedge clk) begin
        if (pop_a && rst_n && fa.size() > 0) rd_data_a <= fa.pop_front();
        if (pop_b && rst_n && fb.size() > 0) rd_data_b <= fb.pop_front();
        empty_a <= (fa.size() == 0);
        empty_b <= (fb.size() == 0);
    end

    // scoreboard: element stream in push order
    logic [DW-1:0] exp_q[$];
    logic [WW-1:0] got_data[$];
    logic [PN-1:0] got_keep[$];
    int            got_cyc[$];
    int            va_cnt = 0;
    logic          hold_v = 1'b0;
    logic [WW-1:0] hold_d = '0;
    logic [PN-1:0] hold_k = '0;

    always @(negedge clk) begin
        int            k;
        logic [WW-1:0] e;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", oa.out_valid, 1);
                chk("hold_data", oa.out_data, hold_d);
                chk("hold_keep", oa.out_keep, hold_k);
            end
            if (oa.out_valid) va_cnt++;
            if (oa.out_valid && oa.out_ready) begin
                k = $countones(oa.out_keep);
                chk("keep_shape", oa.out_keep,
                    (64'd1 << k) - 64'd1 | (k == 0 ? 64'h100 : 64'd0));
                chk("sb_avail", exp_q.size() >= k, 1);
                e = '0;
                for (int i = 0; i < k; i++) begin
                    if (exp_q.size() > 0) e[i*DW +: DW] = exp_q.pop_front();
                end
                chk("word_data", oa.out_data, e);
                got_data.push_back(oa.out_data);
                got_keep.push_back(oa.out_keep);
                got_cyc.push_back(cyc);
            end
            hold_v = oa.out_valid && !oa.out_ready;
            hold_d = oa.out_data;
            hold_k = oa.out_keep;
        end
    end

    int            vb_cnt = 0;
    logic [WW-1:0] last_b_data = '0;
    logic [PN-1:0] last_b_keep = '0;
    always @(negedge clk) begin
        if (rst_n && ob.out_valid) begin
            vb_cnt++;
            last_b_data = ob.out_data;
            last_b_keep = ob.out_keep;
        end
    end

    task automatic push_a(input logic [DW-1:0] v);
        fa.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic wait_words(input int n, input int budget);
        int t = 0;
        while (got_data.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk("wait_word", got_data.size() >= n, 1);
    endtask

    initial begin
        int base;
        int p0;
        int v0;
        oa.out_ready = 1'b0;
        ob.out_ready = 1'b1;
        #1;
        chk("rst_rd_en", rd_en_a, 0);
        chk("rst_valid", oa.out_valid, 0);
        chk("rst_data", oa.out_data, 0);
        chk("rst_keep", oa.out_keep, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        oa.out_ready = 1'b1;
        tick();

        // full word from a preloaded FIFO
        p0 = pops_a;
        v0 = va_cnt;
        base = got_data.size();
        push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
        wait_words(base + 1, 30);
        repeat (4) tick();
        chk("t1_data", got_data[base], 32'h44332211);
        chk("t1_keep", got_keep[base], 4'b1111);
        chk("t1_pops", pops_a - p0, 4);
        chk("t1_valid_cycles", va_cnt - v0, 1);

        // streaming with a blocked output
        oa.out_ready = 1'b0;
        p0 = pops_a;
        base = got_data.size();
        for (int i = 1; i <= 8; i++) push_a(8'(i));
        repeat (14) tick();
        chk("t2_pops", pops_a - p0, 8);
        chk("t2_rd_en_low", rd_en_a, 0);
        chk("t2_valid", oa.out_valid, 1);
        chk("t2_held", oa.out_data, 32'h04030201);
        oa.out_ready = 1'b1;
        wait_words(base + 2, 20);
        chk("t2_w0", got_data[base], 32'h04030201);
        chk("t2_w1", got_data[base+1], 32'h08070605);
        chk("t2_b2b", got_cyc[base+1] - got_cyc[base], 1);

        // explicit flush of a partial word, then an empty flush
        base = got_data.size();
        push_a(8'hAA); push_a(8'hBB);
        repeat (6) tick();
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        wait_words(base + 1, 20);
        chk("t3_data", got_data[base], 32'h0000BBAA);
        chk("t3_keep", got_keep[base], 4'b0011);
        repeat (3) tick();
        base = got_data.size();
        v0 = va_cnt;
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        repeat (6) tick();
        chk("t3_empty_flush", got_data.size(), base);
        chk("t3_empty_valid", va_cnt - v0, 0);

        // idle timeout emits a partial word
        base = got_data.size();
        push_a(8'h31); push_a(8'h32); push_a(8'h33);
        wait_words(base + 1, 40);
        chk("t4_keep", got_keep[base], 4'b0111);
        chk("t4_data", got_data[base], 32'h00333231);
        chk("t4_latency", got_cyc[base] - last_pop_a, 18);

        fb.push_back(8'h41); fb.push_back(8'h52); fb.push_back(8'h63);
        repeat (40) tick();
        chk("t4_no_timeout", vb_cnt, 0);
        flush_b = 1'b1;
        tick();
        flush_b = 1'b0;
        repeat (6) tick();
        chk("t4b_count", vb_cnt, 1);
        chk("t4b_data", last_b_data, 32'h00635241);
        chk("t4b_keep", last_b_keep, 4'b0111);

        // flush in the cycle of an accepted pop
        base = got_data.size();
        push_a(8'hC1); push_a(8'hC2); push_a(8'hC3);
        for (int t = 0; t < 10 && !rd_en_a; t++) tick();
        chk("t5_first_pop", rd_en_a, 1);
        tick();
        chk("t5_second_pop", rd_en_a, 1);
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        chk("t5_blocked0", rd_en_a, 0);
        tick();
        chk("t5_blocked1", rd_en_a, 0);
        wait_words(base + 1, 20);
        chk("t5_keep", got_keep[base], 4'b0011);
        chk("t5_data", got_data[base], 32'h0000C2C1);
        wait_words(base + 2, 40);
        chk("t5_rest", got_keep[base+1], 4'b0001);

        // reset with a held word and a partial fill
        oa.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) push_a(8'hE0 + 8'(i));
        repeat (20) tick();
        chk("t6_pre_valid", oa.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rd_en", rd_en_a, 0);
        chk("t6_valid", oa.out_valid, 0);
        chk("t6_data", oa.out_data, 0);
        chk("t6_keep", oa.out_keep, 0);
        fa.delete();
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        oa.out_ready = 1'b1;
        tick();
        base = got_data.size();
        push_a(8'h5A); push_a(8'h6B); push_a(8'h7C); push_a(8'h8D);
        wait_words(base + 1, 30);
        chk("t6_clean", got_data[base], 32'h8D7C6B5A);
        chk("t6_clean_keep", got_keep[base], 4'b1111);

        // randomized traffic, back-pressure and flushes
        for (int c = 0; c < 600; c++) begin
            tick();
            if ($urandom_range(0, 2) == 0) push_a(8'($urandom));
            oa.out_ready = ($urandom_range(0, 3) != 0);
            flush_a = ($urandom_range(0, 19) == 0);
        end
        tick();
        flush_a = 1'b0;
        oa.out_ready = 1'b1;
        for (int t = 0; t < 300 && exp_q.size() > 0; t++) tick();
        chk("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
